dot_scan_controller: RTL and testbench
======================================

DOT_SCAN_CONTROLLER -- requirements
Module: dot_scan_controller

Interface
REQ-001 Parameter MEM_LENGTH, default 128: matrix dimension (rows = columns).
REQ-002 Parameter MEM_ADDRESS_LENGTH, default 7: row/column index width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  begin scan; sampled in IDLE only.
- stop  input  1  abort scan; sampled in FIRE/GAP.
- loop_en  input  1  repeat frames until stop.
- scan_mode  input  1  0 = row-major (column fastest), 1 = column-major (row fastest).
- row_last  input  MEM_ADDRESS_LENGTH  last row index scanned.
- col_last  input  MEM_ADDRESS_LENGTH  last column index scanned.
- on_cycles  input  16  fire-window length in clocks.
- off_cycles  input  16  gap length in clocks.
- firing_bit  input  1  pattern bit from the dot datapath at current select.
- firing_data  input  1  dot-data bit from the dot datapath at current select.
- row_select  output  MEM_ADDRESS_LENGTH  row index to the datapath.
- col_select  output  MEM_ADDRESS_LENGTH  column index to the datapath.
- row_col_select  output  1  datapath sel-table index source; equals latched scan_mode.
- fire_out  output  1  gated motor drive.
- busy  output  1  high in FIRE and GAP.
- done  output  1  one-cycle pulse on normal frame completion.
- frame_count  output  16  completed frames since start.

Function
REQ-004 FSM states SHALL be IDLE, FIRE, GAP, DONE, encoded in registers.
REQ-005 In IDLE, start=1 SHALL latch scan_mode, row_last, col_last, on_cycles, off_cycles, and loop_en; clear row/col selects, frame_count, and the dwell counter; and enter FIRE next cycle. Config inputs SHALL be ignored outside this event.
REQ-006 FIRE SHALL last max(on_cycles,1) clocks, then enter GAP.
REQ-007 GAP SHALL last off_cycles clocks; off_cycles=0 SHALL make GAP last zero clocks, i.e. FIRE advances position and returns to FIRE directly.
REQ-008 Position advance SHALL occur on the GAP-to-FIRE (or GAP-to-DONE) transition only.
- Row-major: col_select++; when col_select==col_last, col_select wraps to 0 and row_select++.
- Column-major: symmetric, with row fastest.
REQ-009 At the last position (row_select==row_last and col_select==col_last), advance SHALL do the following.
- loop_en=1: wrap both selects to 0, increment frame_count, re-enter FIRE.
- loop_en=0: increment frame_count, enter DONE.
REQ-010 DONE SHALL assert done for exactly one cycle, then enter IDLE; selects SHALL hold their last values until the next start.
REQ-011 stop=1 in FIRE or GAP SHALL enter IDLE next cycle with no done pulse, no frame_count change, and selects held. stop SHALL have priority over any simultaneous end-of-dwell.
REQ-012 fire_out SHALL equal (state==FIRE) AND firing_bit AND firing_data, combinationally, because the datapath is combinational from the selects.
REQ-013 busy SHALL be high in FIRE and GAP and low in IDLE and DONE.
REQ-014 frame_count SHALL wrap from 0xFFFF to 0.
REQ-015 row_last or col_last >= MEM_LENGTH SHALL be clamped to MEM_LENGTH-1 at latch time.
REQ-016 The dwell counter SHALL be 16 bits, reload on every state entry, and count down to its terminal value.

Reset
REQ-017 reset_n=0 at a clock edge SHALL force IDLE and clear all state, including mid-scan. Resulting output values:
- row_select=0, col_select=0, row_col_select=0
- fire_out=0, busy=0, done=0
- frame_count=0
REQ-018 start held high through reset release SHALL begin the scan on the first edge with reset_n=1.

Verification
REQ-019 Row-major 2x3 scan: row_last=1, col_last=2, on=2, off=1, loop_en=0, firing_bit/firing_data tied 1.
- (row,col) sequence SHALL be (0,0)(0,1)(0,2)(1,0)(1,1)(1,2).
- fire_out SHALL be high 2 cycles per position.
- done SHALL pulse once, 18 cycles after FIRE entry.
- frame_count SHALL end at 1.
REQ-020 Column-major: same config with scan_mode=1 SHALL give row_col_select=1 and order (0,0)(1,0)(0,1)(1,1)(0,2)(1,2).
REQ-021 Loop and stop: loop_en=1, 1x1 (row_last=0, col_last=0), on=1, off=0.
- frame_count SHALL increment every cycle.
- stop at frame_count=5 SHALL give IDLE next cycle, no done, frame_count=5.
REQ-022 Gating: firing_data=0 during FIRE SHALL hold fire_out=0 while busy=1; fire_out SHALL be 0 in GAP regardless of inputs.
REQ-023 Edge values: on_cycles=0 SHALL give a 1-cycle FIRE; col_last=200 SHALL clamp to 127 and the scan SHALL wrap after col 127.
REQ-024 Reset mid-scan at position (1,1) in GAP SHALL give all outputs zero the next cycle; a new start SHALL rescan from (0,0).

Source files
------------

// File: rtl/dot_scan_controller.sv
// Raster scan controller for the dot-matrix firing head: walks the row/column
// selects through a configured window with a fire/gap dwell per position.
module dot_scan_controller #(
    parameter int unsigned MEM_LENGTH         = 128,
    parameter int unsigned MEM_ADDRESS_LENGTH = 7
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          loop_en,
    input  logic                          scan_mode,
    input  logic [MEM_ADDRESS_LENGTH-1:0] row_last,
    input  logic [MEM_ADDRESS_LENGTH-1:0] col_last,
    input  logic [15:0]                   on_cycles,
    input  logic [15:0]                   off_cycles,
    input  logic                          firing_bit,
    input  logic                          firing_data,
    output logic [MEM_ADDRESS_LENGTH-1:0] row_select,
    output logic [MEM_ADDRESS_LENGTH-1:0] col_select,
    output logic                          row_col_select,
    output logic                          fire_out,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   frame_count
);

    localparam int unsigned AW = MEM_ADDRESS_LENGTH;
    localparam int unsigned DW = 16;
    localparam logic [AW:0]   LEN_W    = (AW+1)'(MEM_LENGTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(MEM_LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRE,
        S_GAP,
        S_DONE
    } state_t;

    state_t          state;
    logic [DW-1:0]   dwell;
    logic [AW-1:0]   cfg_row_last;
    logic [AW-1:0]   cfg_col_last;
    logic [DW-1:0]   cfg_on;
    logic [DW-1:0]   cfg_off;
    logic            cfg_loop;

    logic            row_end;
    logic            col_end;
    logic            pos_last;
    logic            dwell_end;
    logic            step;
    logic [AW-1:0]   adv_row;
    logic [AW-1:0]   adv_col;
    logic [DW-1:0]   fire_load;
    logic [DW-1:0]   start_fire_load;
    logic [DW-1:0]   gap_load;
    logic [AW-1:0]   clamp_row;
    logic [AW-1:0]   clamp_col;

    // Next scan position, dwell reload values and clamped limits.
    always_comb begin
        row_end   = (row_select == cfg_row_last);
        col_end   = (col_select == cfg_col_last);
        pos_last  = row_end && col_end;
        dwell_end = (dwell == '0);
        // A position ends after FIRE when there is no gap, otherwise after GAP.
        step      = dwell_end && (((state == S_FIRE) && (cfg_off == '0)) || (state == S_GAP));

        adv_row = row_select;
        adv_col = col_select;
        if (pos_last) begin
            adv_row = '0;
            adv_col = '0;
        end else if (!row_col_select) begin
            if (col_end) begin
                adv_col = '0;
                adv_row = row_select + AW'(1);
            end else begin
                adv_col = col_select + AW'(1);
            end
        end else begin
            if (row_end) begin
                adv_row = '0;
                adv_col = col_select + AW'(1);
            end else begin
                adv_row = row_select + AW'(1);
            end
        end

        fire_load       = (cfg_on == '0) ? '0 : cfg_on - DW'(1);
        start_fire_load = (on_cycles == '0) ? '0 : on_cycles - DW'(1);
        gap_load        = cfg_off - DW'(1);

        clamp_row = ({1'b0, row_last} >= LEN_W) ? LAST_IDX : row_last;
        clamp_col = ({1'b0, col_last} >= LEN_W) ? LAST_IDX : col_last;
    end

    // Scan FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            dwell          <= '0;
            cfg_row_last   <= '0;
            cfg_col_last   <= '0;
            cfg_on         <= '0;
            cfg_off        <= '0;
            cfg_loop       <= 1'b0;
            row_select     <= '0;
            col_select     <= '0;
            row_col_select <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            frame_count    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cfg_row_last   <= clamp_row;
                        cfg_col_last   <= clamp_col;
                        cfg_on         <= on_cycles;
                        cfg_off        <= off_cycles;
                        cfg_loop       <= loop_en;
                        row_col_select <= scan_mode;
                        row_select     <= '0;
                        col_select     <= '0;
                        frame_count    <= '0;
                        dwell          <= start_fire_load;
                        busy           <= 1'b1;
                        state          <= S_FIRE;
                    end
                end
                S_FIRE, S_GAP: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (step) begin
                        if (pos_last) begin
                            frame_count <= frame_count + DW'(1);
                        end
                        if (pos_last && !cfg_loop) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            row_select <= adv_row;
                            col_select <= adv_col;
                            dwell      <= fire_load;
                            state      <= S_FIRE;
                        end
                    end else if (dwell_end) begin
                        dwell <= gap_load;
                        state <= S_GAP;
                    end else begin
                        dwell <= dwell - DW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath is combinational from the selects, so gating stays combinational too.
    assign fire_out = (state == S_FIRE) && firing_bit && firing_data;

endmodule

// File: tb/tb_dot_scan_controller.sv
// Self-checking bench for dot_scan_controller: expected per-cycle outputs are
// generated by enumerating scan positions and dwell windows.
module tb_dot_scan_controller;

    localparam int MEM = 128;
    localparam int AW  = 8;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start, stop, loop_en, scan_mode;
    logic [AW-1:0] row_last, col_last;
    logic [15:0]   on_cycles, off_cycles;
    logic          firing_bit, firing_data;
    logic [AW-1:0] row_select, col_select;
    logic          row_col_select, fire_out, busy, done;
    logic [15:0]   frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        fire;
        logic        busy;
        logic        done;
        logic [15:0] fc;
        logic [7:0]  row;
        logic [7:0]  col;
    } exp_t;

    exp_t q[$];

    dot_scan_controller #(.MEM_LENGTH(MEM), .MEM_ADDRESS_LENGTH(AW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
        .loop_en(loop_en), .scan_mode(scan_mode), .row_last(row_last),
        .col_last(col_last), .on_cycles(on_cycles), .off_cycles(off_cycles),
        .firing_bit(firing_bit), .firing_data(firing_data),
        .row_select(row_select), .col_select(col_select),
        .row_col_select(row_col_select), .fire_out(fire_out), .busy(busy),
        .done(done), .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic exp_t mk(input logic f, input logic b, input logic d,
                                input int fc, input int r, input int c);
        exp_t e;
        e.fire = f;
        e.busy = b;
        e.done = d;
        e.fc   = 16'(fc);
        e.row  = 8'(r);
        e.col  = 8'(c);
        return e;
    endfunction

    task automatic check(input string tag, input exp_t e, input logic rcs);
        logic [35:0] obs, req;
        obs = {fire_out, busy, done, frame_count, row_select, col_select, row_col_select};
        req = {e.fire & firing_bit & firing_data, e.busy, e.done, e.fc, e.row, e.col, rcs};
        n_checks++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed fire/busy/done/fc/row/col/rcs=%b/%b/%b/%0d/%0d/%0d/%b required %b/%b/%b/%0d/%0d/%0d/%b",
                   tag, obs[35], obs[34], obs[33], obs[32:17], obs[16:9], obs[8:1], obs[0],
                   req[35], req[34], req[33], req[32:17], req[16:9], req[8:1], req[0]);
        end
    endtask

    // Expected cycle stream: every position in scan order gets max(on,1) FIRE
    // cycles and off GAP cycles; a single frame ends with DONE then IDLE.
    task automatic build(input bit mode, input int rl, input int cl, input int on,
                         input int off, input bit loop, input int frames);
        int rlc, clc, on_e, npos, r, c;
        rlc  = (rl >= MEM) ? MEM - 1 : rl;
        clc  = (cl >= MEM) ? MEM - 1 : cl;
        on_e = (on == 0) ? 1 : on;
        npos = (rlc + 1) * (clc + 1);
        q.delete();
        for (int f = 0; f < frames; f++) begin
            for (int i = 0; i < npos; i++) begin
                r = mode ? i % (rlc + 1) : i / (clc + 1);
                c = mode ? i / (rlc + 1) : i % (clc + 1);
                for (int k = 0; k < on_e; k++) q.push_back(mk(1'b1, 1'b1, 1'b0, f, r, c));
                for (int k = 0; k < off; k++)  q.push_back(mk(1'b0, 1'b1, 1'b0, f, r, c));
            end
        end
        if (!loop) begin
            q.push_back(mk(1'b0, 1'b0, 1'b1, frames, rlc, clc));
            q.push_back(mk(1'b0, 1'b0, 1'b0, frames, rlc, clc));
        end
    endtask

    // Walk the expected stream; config and start are scrambled while they
    // must be ignored. abort_kind 1 = stop, 2 = reset at record abort_idx.
    task automatic stream(input string name, input bit mode, input bit tie_fire,
                          input int abort_idx, input int abort_kind);
        for (int n = 0; n < q.size(); n++) begin
            firing_bit  = tie_fire ? 1'b1 : 1'($urandom);
            firing_data = tie_fire ? 1'b1 : 1'($urandom);
            start       = (q[n].busy || q[n].done) ? 1'($urandom) : 1'b0;
            scan_mode   = 1'($urandom);
            loop_en     = 1'($urandom);
            row_last    = 8'($urandom);
            col_last    = 8'($urandom);
            on_cycles   = 16'($urandom);
            off_cycles  = 16'($urandom);
            #1;
            check($sformatf("%s cyc%0d", name, n), q[n], mode);
            if (n == abort_idx) begin
                if (abort_kind == 1) stop = 1'b1;
                if (abort_kind == 2) reset_n = 1'b0;
                tick();
                start = 1'b0;
                stop  = 1'b0;
                return;
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic launch(input bit mode, input int rl, input int cl, input int on,
                          input int off, input bit loop);
        scan_mode  = mode;
        row_last   = 8'(rl);
        col_last   = 8'(cl);
        on_cycles  = 16'(on);
        off_cycles = 16'(off);
        loop_en    = loop;
        start      = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_scan(input string name, input bit mode, input int rl, input int cl,
                            input int on, input int off);
        build(mode, rl, cl, on, off, 1'b0, 1);
        launch(mode, rl, cl, on, off, 1'b0);
        stream(name, mode, 1'b0, -1, 0);
    endtask

    initial begin
        exp_t e;
        int   m, rl, cl, on, off;
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; scan_mode = 1'b0;
        row_last = '0; col_last = '0; on_cycles = '0; off_cycles = '0;
        firing_bit = 1'b1; firing_data = 1'b1;
        tick();
        tick();
        check("reset", mk(1'b0, 1'b0, 1'b0, 0, 0, 0), 1'b0);

        // Start held through reset release; 2x3 row-major, firing tied high.
        scan_mode = 1'b0; row_last = 8'd1; col_last = 8'd2;
        on_cycles = 16'd2; off_cycles = 16'd1; loop_en = 1'b0; start = 1'b1;
        tick();
        check("reset with start", mk(1'b0, 1'b0, 1'b0, 0, 0, 0), 1'b0);
        reset_n = 1'b1;
        tick();
        start = 1'b0;
        build(1'b0, 1, 2, 2, 1, 1'b0, 1);
        stream("row-major 2x3", 1'b0, 1'b1, -1, 0);

        // Column-major, same window.
        build(1'b1, 1, 2, 2, 1, 1'b0, 1);
        launch(1'b1, 1, 2, 2, 1, 1'b0);
        stream("col-major 2x3", 1'b1, 1'b1, -1, 0);

        // 1x1 looping with no gap, stopped when frame_count reads 5.
        build(1'b0, 0, 0, 1, 0, 1'b1, 10);
        launch(1'b0, 0, 0, 1, 0, 1'b1);
        stream("loop", 1'b0, 1'b0, 5, 1);
        e = mk(1'b0, 1'b0, 1'b0, 5, 0, 0);
        check("after stop", e, 1'b0);
        tick();
        check("after stop +1", e, 1'b0);

        // Edge values: zero on-time, wide clamp in each orientation.
        run_scan("on=0", 1'b0, 1, 1, 0, 2);
        run_scan("col clamp", 1'b0, 0, 200, 1, 0);
        run_scan("row clamp", 1'b1, 250, 0, 1, 0);

        // Reset during the GAP at (1,1), then a fresh scan from (0,0).
        build(1'b0, 1, 2, 2, 1, 1'b0, 1);
        launch(1'b0, 1, 2, 2, 1, 1'b0);
        stream("pre-reset", 1'b0, 1'b0, 14, 2);
        reset_n = 1'b1;
        check("mid-scan reset", mk(1'b0, 1'b0, 1'b0, 0, 0, 0), 1'b0);
        run_scan("rescan", 1'b0, 1, 2, 2, 1);

        for (int i = 0; i < 6; i++) begin
            m   = int'($urandom_range(0, 1));
            rl  = int'($urandom_range(0, 3));
            cl  = int'($urandom_range(0, 3));
            on  = int'($urandom_range(0, 3));
            off = int'($urandom_range(0, 2));
            run_scan($sformatf("rand%0d", i), 1'(m), rl, cl, on, off);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
